// File: rtl/branch_predict_unit_pkg.sv
// Shared pipeline definitions: opcodes, branch funct3 codes and BTB counter helpers.
package branch_predict_unit_pkg;

    // Control-transfer opcodes.
    localparam logic [6:0] OPC_B_TYPE  = 7'b1100011;
    localparam logic [6:0] OPC_J_TYPE  = 7'b1101111;
    localparam logic [6:0] OPC_JR_TYPE = 7'b1100111;

    // Branch funct3 codes.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating counter encodings used on allocation.
    localparam logic [1:0] CNT_WEAK_TAKEN   = 2'b10;
    localparam logic [1:0] CNT_STRONG_TAKEN = 2'b11;

    // Saturating counter step: up on taken, down on not taken.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && (cnt != 2'b11)) begin
            res = cnt + 2'b01;
        end else if (!taken && (cnt != 2'b00)) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Combinational branch condition evaluator: all six RV32 branch conditions plus JAL/JALR.
module branch_cond_eval
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_brop,
    input  logic [XLEN-1:0] i_data1,
    input  logic [XLEN-1:0] i_data2,
    output logic            o_taken
);

    // Decode the branch outcome; unknown funct3 on a B-type resolves as not taken.
    always_comb begin
        o_taken = 1'b0;
        if (i_opcode == OPC_B_TYPE) begin
            case (i_brop)
                F3_BEQ:  o_taken = (i_data1 == i_data2);
                F3_BNE:  o_taken = (i_data1 != i_data2);
                F3_BLT:  o_taken = ($signed(i_data1) < $signed(i_data2));
                F3_BGE:  o_taken = ($signed(i_data1) >= $signed(i_data2));
                F3_BLTU: o_taken = (i_data1 < i_data2);
                F3_BGEU: o_taken = (i_data1 >= i_data2);
                default: o_taken = 1'b0;
            endcase
        end else if ((i_opcode == OPC_J_TYPE) || (i_opcode == OPC_JR_TYPE)) begin
            o_taken = 1'b1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution: direct-mapped BTB with 2-bit counters, EX-stage
// resolver with registered redirect, and wrapping branch/mispredict event counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic [6:0]      i_ex_opcode,
    input  logic [2:0]      i_ex_brop,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_data1,
    input  logic [XLEN-1:0] i_ex_data2,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_br_count,
    output logic [31:0]     o_mis_count
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    // BTB storage; only the valid bits are reset.
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_target [BTB_ENTRIES];
    logic [1:0]             r_cnt    [BTB_ENTRIES];

    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_br_count;
    logic [31:0]     r_mis_count;

    logic [IDX-1:0]  w_if_idx;
    logic [TAGW-1:0] w_if_tag;
    logic            w_if_hit;
    logic [IDX-1:0]  w_ex_idx;
    logic [TAGW-1:0] w_ex_tag;
    logic            w_ex_hit;
    logic            w_is_b;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_resolve;
    logic            w_taken;
    logic [XLEN-1:0] w_actual_pc;
    logic            w_mispredict;
    logic            w_wr_en;
    logic [1:0]      w_wr_cnt;
    logic [XLEN-1:0] w_wr_target;
    logic [1:0]      w_unused_bits;

    assign w_unused_bits = i_if_pc[1:0];

    // IF lookup reads registered state, so a same-cycle update is not visible here.
    assign w_if_idx      = i_if_pc[IDX+1:2];
    assign w_if_tag      = i_if_pc[XLEN-1:IDX+2];
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign o_pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
    assign o_pred_target = r_target[w_if_idx];

    assign w_ex_idx = i_ex_pc[IDX+1:2];
    assign w_ex_tag = i_ex_pc[XLEN-1:IDX+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    assign w_is_b    = (i_ex_opcode == OPC_B_TYPE);
    assign w_is_jal  = (i_ex_opcode == OPC_J_TYPE);
    assign w_is_jalr = (i_ex_opcode == OPC_JR_TYPE);
    assign w_resolve = i_ex_valid && (w_is_b || w_is_jal || w_is_jalr);

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond (
        .i_opcode (i_ex_opcode),
        .i_brop   (i_ex_brop),
        .i_data1  (i_ex_data1),
        .i_data2  (i_ex_data2),
        .o_taken  (w_taken)
    );

    assign w_actual_pc  = w_taken ? i_ex_target : (i_ex_pc + XLEN'(4));
    assign w_mispredict = (w_taken != i_ex_pred_taken) ||
                          (w_taken && (i_ex_pred_target != i_ex_target));

    // BTB write request: B-type trains on hit or allocates on taken miss, JAL always
    // allocates strongly taken, JALR never writes.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_cnt    = r_cnt[w_ex_idx];
        w_wr_target = r_target[w_ex_idx];
        if (i_ex_valid) begin
            if (w_is_b) begin
                if (w_ex_hit) begin
                    w_wr_en  = 1'b1;
                    w_wr_cnt = cnt_next(r_cnt[w_ex_idx], w_taken);
                    if (w_taken) begin
                        w_wr_target = i_ex_target;
                    end
                end else if (w_taken) begin
                    w_wr_en     = 1'b1;
                    w_wr_cnt    = CNT_WEAK_TAKEN;
                    w_wr_target = i_ex_target;
                end
            end else if (w_is_jal) begin
                w_wr_en     = 1'b1;
                w_wr_cnt    = CNT_STRONG_TAKEN;
                w_wr_target = i_ex_target;
            end
        end
    end

    // Valid bits: cleared by reset, set on any BTB write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[w_ex_idx] <= 1'b1;
        end
    end

    // Entry payload: no reset needed since valid gates every use.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= w_wr_target;
            r_cnt[w_ex_idx]    <= w_wr_cnt;
        end
    end

    // One-cycle redirect pulse on mispredict; redirect_pc holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (w_resolve && w_mispredict) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_actual_pc;
        end else begin
            r_redirect    <= 1'b0;
        end
    end

    // Wrapping event counters for resolved control transfers and mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else if (w_resolve) begin
            r_br_count <= r_br_count + 32'd1;
            if (w_mispredict) begin
                r_mis_count <= r_mis_count + 32'd1;
            end
        end
    end

    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_br_count    = r_br_count;
    assign o_mis_count   = r_mis_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus pushes expectations, a monitor checks them.
module tb_branch_predict_unit;

    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] br;
        logic [31:0] mis;
    } res_t;

    typedef struct packed {
        logic        tk;
        logic        chk_tg;
        logic [31:0] tg;
    } lk_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_brop;
    logic [31:0] ex_pc;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    int n_total = 0;
    int n_bad   = 0;

    res_t  q_res[$];
    string q_res_nm[$];
    lk_t   q_lk[$];
    string q_lk_nm[$];

    logic        lk_req;
    logic        ex_pend;
    logic        lk_pend;
    logic        lk_pt;
    logic [31:0] lk_tg;

    branch_predict_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_ex_valid       (ex_valid),
        .i_ex_opcode      (ex_opcode),
        .i_ex_brop        (ex_brop),
        .i_ex_pc          (ex_pc),
        .i_ex_data1       (ex_data1),
        .i_ex_data2       (ex_data2),
        .i_ex_target      (ex_target),
        .i_ex_pred_taken  (ex_pred_taken),
        .i_ex_pred_target (ex_pred_target),
        .o_redirect       (redirect),
        .o_redirect_pc    (redirect_pc),
        .o_br_count       (br_count),
        .o_mis_count      (mis_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Mark which edges carried a resolve or a lookup, and capture lookup outputs pre-update.
    always @(posedge clk) begin
        ex_pend <= ex_valid && rst_n;
        lk_pend <= lk_req;
        lk_pt   <= pred_taken;
        lk_tg   <= pred_target;
    end

    // Monitor: pop and compare whenever the DUT has produced a response.
    always @(negedge clk) begin
        res_t  er;
        lk_t   el;
        string nm;
        if (ex_pend) begin
            if (q_res.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_resolve: got response expected none");
            end else begin
                er = q_res.pop_front();
                nm = q_res_nm.pop_front();
                chk({nm, ".redirect"}, {31'd0, redirect}, {31'd0, er.redir});
                chk({nm, ".redirect_pc"}, redirect_pc, er.rpc);
                chk({nm, ".br_count"}, br_count, er.br);
                chk({nm, ".mis_count"}, mis_count, er.mis);
            end
        end
        if (lk_pend) begin
            if (q_lk.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_lookup: got response expected none");
            end else begin
                el = q_lk.pop_front();
                nm = q_lk_nm.pop_front();
                chk({nm, ".pred_taken"}, {31'd0, lk_pt}, {31'd0, el.tk});
                if (el.chk_tg) begin
                    chk({nm, ".pred_target"}, lk_tg, el.tg);
                end
            end
        end
    end

    task automatic resolve(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                           input logic xredir, input logic [31:0] xrpc,
                           input logic [31:0] xbr, input logic [31:0] xmis);
        res_t e;
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_opcode      = opc;
        ex_brop        = f3;
        ex_pc          = pc;
        ex_data1       = d1;
        ex_data2       = d2;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        e.redir = xredir;
        e.rpc   = xrpc;
        e.br    = xbr;
        e.mis   = xmis;
        q_res.push_back(e);
        q_res_nm.push_back(nm);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc, input logic xtk,
                          input logic xchk, input logic [31:0] xtg);
        lk_t e;
        @(negedge clk);
        if_pc  = pc;
        lk_req = 1'b1;
        e.tk     = xtk;
        e.chk_tg = xchk;
        e.tg     = xtg;
        q_lk.push_back(e);
        q_lk_nm.push_back(nm);
        @(negedge clk);
        lk_req = 1'b0;
    endtask

    localparam logic [6:0] B   = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] ALU = 7'b0110011;

    initial begin
        rst_n          = 1'b0;
        if_pc          = 32'h100;
        lk_req         = 1'b0;
        ex_valid       = 1'b0;
        ex_opcode      = '0;
        ex_brop        = '0;
        ex_pc          = '0;
        ex_data1       = '0;
        ex_data2       = '0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
        repeat (3) @(negedge clk);
        chk("reset.redirect", {31'd0, redirect}, 32'd0);
        chk("reset.redirect_pc", redirect_pc, 32'd0);
        chk("reset.br_count", br_count, 32'd0);
        chk("reset.mis_count", mis_count, 32'd0);
        rst_n = 1'b1;

        lookup("lk_cold_100", 32'h100, 1'b0, 1'b0, 32'h0);
        resolve("beq_alloc", B, 3'b000, 32'h100, 32'd5, 32'd5, 32'h80, 1'b0, 32'h0,
                1'b1, 32'h80, 32'd1, 32'd1);
        lookup("lk_after_beq", 32'h100, 1'b1, 1'b1, 32'h80);

        resolve("blt_signed", B, 3'b100, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'h280, 1'b1, 32'h280,
                1'b0, 32'h80, 32'd2, 32'd1);
        resolve("bltu_unsigned", B, 3'b110, 32'h308, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b0, 32'h0,
                1'b0, 32'h80, 32'd3, 32'd1);
        lookup("lk_nt_miss_nowrite", 32'h308, 1'b0, 1'b0, 32'h0);

        // Counter walk at 0x100: 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01.
        resolve("bne_t2", B, 3'b001, 32'h100, 32'd1, 32'd2, 32'h80, 1'b1, 32'h80,
                1'b0, 32'h80, 32'd4, 32'd1);
        resolve("bne_t3", B, 3'b001, 32'h100, 32'd1, 32'd2, 32'h80, 1'b1, 32'h80,
                1'b0, 32'h80, 32'd5, 32'd1);
        lookup("lk_cnt11", 32'h100, 1'b1, 1'b1, 32'h80);
        resolve("bne_nt1", B, 3'b001, 32'h100, 32'd3, 32'd3, 32'h80, 1'b1, 32'h80,
                1'b1, 32'h104, 32'd6, 32'd2);
        lookup("lk_cnt10", 32'h100, 1'b1, 1'b1, 32'h80);
        resolve("bne_nt2", B, 3'b001, 32'h100, 32'd3, 32'd3, 32'h80, 1'b1, 32'h80,
                1'b1, 32'h104, 32'd7, 32'd3);
        lookup("lk_cnt01", 32'h100, 1'b0, 1'b1, 32'h80);
        resolve("bne_nt3", B, 3'b001, 32'h100, 32'd3, 32'd3, 32'h80, 1'b0, 32'h0,
                1'b0, 32'h104, 32'd8, 32'd3);
        resolve("bne_nt_sat", B, 3'b001, 32'h100, 32'd3, 32'd3, 32'h80, 1'b0, 32'h0,
                1'b0, 32'h104, 32'd9, 32'd3);
        resolve("bne_t_from00", B, 3'b001, 32'h100, 32'd1, 32'd2, 32'h80, 1'b0, 32'h0,
                1'b1, 32'h80, 32'd10, 32'd4);
        lookup("lk_cnt01_again", 32'h100, 1'b0, 1'b1, 32'h80);

        resolve("jalr_target", JR, 3'b000, 32'h200, 32'h0, 32'h0, 32'h344, 1'b1, 32'h340,
                1'b1, 32'h344, 32'd11, 32'd5);
        lookup("lk_jalr_miss", 32'h200, 1'b0, 1'b0, 32'h0);
        resolve("jal_alloc", JAL, 3'b000, 32'h20C, 32'h0, 32'h0, 32'h500, 1'b0, 32'h0,
                1'b1, 32'h500, 32'd12, 32'd6);
        lookup("lk_jal_hit", 32'h20C, 1'b1, 1'b1, 32'h500);
        resolve("alu_ignored", ALU, 3'b000, 32'h210, 32'h0, 32'h0, 32'h900, 1'b1, 32'h900,
                1'b0, 32'h500, 32'd12, 32'd6);

        resolve("bge_alias", B, 3'b101, 32'h200, 32'd2, 32'hFFFF_FFFF, 32'h600, 1'b0, 32'h0,
                1'b1, 32'h600, 32'd13, 32'd7);
        lookup("lk_evicted_100", 32'h100, 1'b0, 1'b0, 32'h0);
        lookup("lk_alias_200", 32'h200, 1'b1, 1'b1, 32'h600);

        resolve("bgeu_nt", B, 3'b111, 32'h310, 32'd1, 32'hFFFF_FFFF, 32'h700, 1'b0, 32'h0,
                1'b0, 32'h600, 32'd14, 32'd7);
        resolve("bad_funct3", B, 3'b010, 32'h314, 32'd1, 32'd1, 32'h700, 1'b1, 32'h700,
                1'b1, 32'h318, 32'd15, 32'd8);
        resolve("pc_wrap", B, 3'b001, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'h40, 1'b1, 32'h40,
                1'b1, 32'h0000_0000, 32'd16, 32'd9);

        // Reset asserted in the same cycle as a mispredicting resolve.
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_opcode      = B;
        ex_brop        = 3'b000;
        ex_pc          = 32'h100;
        ex_data1       = 32'd5;
        ex_data2       = 32'd5;
        ex_target      = 32'h80;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
        rst_n          = 1'b0;
        #1;
        chk("rst_mid.redirect", {31'd0, redirect}, 32'd0);
        chk("rst_mid.br_count", br_count, 32'd0);
        chk("rst_mid.mis_count", mis_count, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held.redirect", {31'd0, redirect}, 32'd0);
        chk("rst_held.redirect_pc", redirect_pc, 32'd0);
        chk("rst_held.br_count", br_count, 32'd0);
        chk("rst_held.mis_count", mis_count, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n    = 1'b1;
        lookup("lk_after_reset", 32'h200, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if ((q_res.size() == 0) && (q_lk.size() == 0)) break;
            @(negedge clk);
        end
        if ((q_res.size() != 0) || (q_lk.size() != 0)) begin
            n_total++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_res.size(), q_lk.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
